// File: rtl/access_ctrl_param_if.sv
// Keypad/load bundle between the access controller and its surroundings.
// master drives keypad and load requests; slave is the controller.
interface access_ctrl_param_if #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  logic [DIGIT_W-1:0] pass_digit;
  logic               pass_enter;
  logic               logout_req;
  logic [NUM_CH-1:0]  load_in;
  logic               log_in;
  logic               log_out;
  logic [NUM_CH-1:0]  load_out;
  logic               locked;
  logic [FAIL_W-1:0]  fail_cnt;

  modport master (
    output pass_digit, pass_enter, logout_req, load_in,
    input  log_in, log_out, load_out, locked, fail_cnt
  );

  modport slave (
    input  pass_digit, pass_enter, logout_req, load_in,
    output log_in, log_out, load_out, locked, fail_cnt
  );
endinterface

// File: rtl/access_ctrl_param.sv
// Code-entry access controller with failed-attempt lockout and per-channel load gating.
// Define ACCESS_IDLE_TIMEOUT_EN to add an idle auto-logout after TIMEOUT_CYCLES.
module access_ctrl_param #(
  parameter int unsigned                 DIGIT_W        = 4,
  parameter int unsigned                 PASS_LEN       = 4,
  parameter logic [PASS_LEN*DIGIT_W-1:0] PASSWORD       = 16'h9861,
  parameter int unsigned                 NUM_CH         = 2,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 LOCK_CYCLES    = 1000,
  parameter int unsigned                 TIMEOUT_CYCLES = 5000
) (
  input logic                clk,
  input logic                rst,
  access_ctrl_param_if.slave bus
);

  localparam int unsigned PW_W   = PASS_LEN * DIGIT_W;
  localparam int unsigned IDX_W  = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PASS_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIM  = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    StEntry,
    StVerify,
    StPending,
    StActive,
    StLockout
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                r_match;
  logic                w_match_nxt;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [FAIL_W-1:0]   w_fail_nxt;
  logic [FAIL_W-1:0]   w_fail_inc;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [LOCK_W-1:0]   w_lock_nxt;
  logic [NUM_CH-1:0]   r_load_out;
  logic [NUM_CH-1:0]   w_load_nxt;
  logic                r_log_in;
  logic                r_log_out;
  logic                r_locked;
  logic                w_session_nxt;
  logic                w_logout;
  logic [PW_W-1:0]     w_pw_shift;
  logic [DIGIT_W-1:0]  w_exp_digit;

  // Digit idx of the stored code, counted from the most significant end.
  assign w_pw_shift  = PASSWORD << (32'(r_idx) * DIGIT_W);
  assign w_exp_digit = w_pw_shift[PW_W-1 -: DIGIT_W];
  assign w_fail_inc  = r_fail_cnt + FAIL_W'(1);

`ifdef ACCESS_IDLE_TIMEOUT_EN
  localparam int unsigned      TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_idle_cnt;
  logic [TO_W-1:0] w_idle_nxt;
  logic            w_activity;
  logic            w_timeout;

  assign w_activity = (|bus.load_in) || bus.pass_enter;
  assign w_timeout  = !w_activity && (r_idle_cnt == TO_LAST) &&
                      ((r_state == StPending) || (r_state == StActive));
  assign w_logout   = bus.logout_req || w_timeout;

  // Counts only idle session cycles; anything else (incl. VERIFY) clears it.
  always_comb begin
    w_idle_nxt = '0;
    if (((r_state == StPending) || (r_state == StActive)) && !w_activity && !w_timeout) begin
      w_idle_nxt = r_idle_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= w_idle_nxt;
    end
  end
`else
  assign w_logout = bus.logout_req;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_match_nxt = r_match;
    w_fail_nxt  = r_fail_cnt;
    w_lock_nxt  = r_lock_cnt;
    w_load_nxt  = '0;

    unique case (r_state)
      StEntry: begin
        // Wrong digits only clear the flag; the full code length is always consumed.
        if (bus.pass_enter) begin
          if (bus.pass_digit != w_exp_digit) begin
            w_match_nxt = 1'b0;
          end
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = StVerify;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end

      StVerify: begin
        w_match_nxt = 1'b1;
        if (r_match) begin
          w_fail_nxt  = '0;
          w_state_nxt = StPending;
        end else begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc == FAIL_LIM) begin
            w_lock_nxt  = '0;
            w_state_nxt = StLockout;
          end else begin
            w_state_nxt = StEntry;
          end
        end
      end

      StLockout: begin
        if (r_lock_cnt == LOCK_LAST) begin
          w_lock_nxt  = '0;
          w_fail_nxt  = '0;
          w_state_nxt = StEntry;
        end else begin
          w_lock_nxt = r_lock_cnt + LOCK_W'(1);
        end
      end

      StPending, StActive: begin
        if (w_logout) begin
          w_state_nxt = StEntry;
        end else begin
          w_load_nxt = bus.load_in;
          if ((r_state == StPending) && (|bus.load_in)) begin
            w_state_nxt = StActive;
          end
        end
      end

      default: begin
        w_state_nxt = StEntry;
        w_idx_nxt   = '0;
        w_match_nxt = 1'b1;
        w_fail_nxt  = '0;
        w_lock_nxt  = '0;
      end
    endcase
  end

  assign w_session_nxt = (w_state_nxt == StPending) || (w_state_nxt == StActive);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StEntry;
      r_idx      <= '0;
      r_match    <= 1'b1;
      r_fail_cnt <= '0;
      r_lock_cnt <= '0;
      r_load_out <= '0;
      r_log_in   <= 1'b0;
      r_log_out  <= 1'b1;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_match    <= w_match_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_load_out <= w_load_nxt;
      r_log_in   <= w_session_nxt;
      r_log_out  <= !w_session_nxt;
      r_locked   <= (w_state_nxt == StLockout);
    end
  end

  assign bus.log_in   = r_log_in;
  assign bus.log_out  = r_log_out;
  assign bus.load_out = r_load_out;
  assign bus.locked   = r_locked;
  assign bus.fail_cnt = r_fail_cnt;

endmodule
